axis_burst_scheduler: RTL and testbench
=======================================

AXIS_BURST_SCHEDULER -- requirements
Module: axis_burst_scheduler

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32, width of m_axis_tdata; SHALL be >= CNTR_WIDTH.
REQ-002 Parameter CNTR_WIDTH, default 32, width of the beat counter, cfg_length and cfg_gap.
REQ-003 Parameter BURST_WIDTH, default 16, width of cfg_bursts and sts_burst.
REQ-004 aclk  in  1  clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, synchronous, active-low.
REQ-006 cfg_length  in  CNTR_WIDTH  beats per burst.
REQ-007 cfg_bursts  in  BURST_WIDTH  bursts per run.
REQ-008 cfg_gap  in  CNTR_WIDTH  idle cycles between bursts.
REQ-009 start  in  1  run request, sampled every cycle.
REQ-010 abort  in  1  terminate request, sampled every cycle.
REQ-011 m_axis_tdata  out  AXIS_TDATA_WIDTH  zero-extended beat index within burst.
REQ-012 m_axis_tvalid  out  1  beat valid.
REQ-013 m_axis_tready  in  1  downstream ready.
REQ-014 m_axis_tlast  out  1  high on final beat of each burst.
REQ-015 sts_busy  out  1  high when state is not IDLE.
REQ-016 sts_burst  out  BURST_WIDTH  count of completed bursts in current/last run.
REQ-017 sts_done  out  1  one-cycle pulse on normal run completion.

Function
REQ-018 FSM states IDLE, RUN, GAP; all outputs registered or decoded from registers only, no combinational path from inputs to outputs.
REQ-019 Handshake: beat transfers when m_axis_tvalid & m_axis_tready; SHALL NOT change tdata/tlast or drop tvalid while tvalid=1 and tready=0.
REQ-020 IDLE: tvalid=0; start=1 with cfg_length!=0 and cfg_bursts!=0 latches length/bursts/gap into shadow regs, clears beat counter and sts_burst, next state RUN; tvalid=1, tdata=0 in cycle after start sampled.
REQ-021 IDLE: start with cfg_length=0 or cfg_bursts=0 ignored; no state change, no sts_done, sts_burst unchanged.
REQ-022 Config inputs changing while sts_busy=1 SHALL have no effect on current run (shadow regs only).
REQ-023 start while sts_busy=1 ignored.
REQ-024 RUN: tvalid=1; tdata=beat counter; tlast=1 iff counter == length-1.
REQ-025 RUN, transfer, not last: counter +1.
REQ-026 RUN, transfer, last: counter=0, sts_burst +1; if new sts_burst == bursts: next IDLE, sts_done=1 for one cycle; else if gap=0: stay RUN (next burst back-to-back, no idle cycle); else next GAP with gap counter=0.
REQ-027 GAP: tvalid=0; gap counter +1 per cycle; exactly gap cycles spent in GAP, then RUN with tdata=0.
REQ-028 Counter comparisons full CNTR_WIDTH; length = 2^CNTR_WIDTH-1 SHALL not wrap before tlast.
REQ-029 abort in GAP: next state IDLE, no sts_done.
REQ-030 abort in RUN: latched as pending; current beat held unchanged until transferred, then IDLE, no sts_done, sts_burst incremented only if that beat had tlast=1.
REQ-031 abort and completing last beat of last burst in same cycle: normal completion, sts_done=1.
REQ-032 abort in IDLE ignored; abort and start same cycle in IDLE: start ignored.

Reset
REQ-033 aresetn=0 at any time, including mid-burst: state IDLE, tvalid=0, tlast=0, tdata=0, sts_busy=0, sts_burst=0, sts_done=0, pending abort cleared, all counters 0.
REQ-034 Reset asserted while tvalid=1 and tready=0 SHALL drop tvalid in the following cycle.

Verification
REQ-035 length=4, bursts=2, gap=3, tready=1, start pulse -> tdata 0,1,2,3(tlast) ; 3 cycles tvalid=0 ; 0,1,2,3(tlast) ; sts_done one cycle ; sts_burst=2 ; sts_busy=0.
REQ-036 length=3, bursts=2, gap=0, tready toggling 1/0 -> 6 beats 0,1,2,0,1,2, tlast on each 2, data stable while tready=0, no idle cycle between bursts.
REQ-037 length=5, bursts=1, abort asserted at beat 2 with tready=0 for 4 cycles -> beat 2 held, transferred, then IDLE, sts_done never pulses, sts_burst=0.
REQ-038 start with cfg_length=0 -> sts_busy stays 0, tvalid stays 0; then cfg change and start mid-run -> run unaffected.
REQ-039 aresetn=0 at beat 1 of burst 1 -> all outputs reset values next cycle; subsequent start runs from tdata=0, sts_burst=0.
REQ-040 length=1, bursts=3, gap=1 -> tdata 0 with tlast=1 on every beat, one idle cycle between, sts_burst counts 1,2,3.

Source files
------------

// File: rtl/axis_burst_scheduler.sv
// AXI-Stream burst scheduler: emits cfg_bursts bursts of cfg_length beats,
// separated by cfg_gap idle cycles. tdata carries the beat index within the
// burst. Configuration is captured into shadow registers when a run starts.
module axis_burst_scheduler #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32,
  parameter int BURST_WIDTH      = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_length,
  input  logic [BURST_WIDTH-1:0]      cfg_bursts,
  input  logic [CNTR_WIDTH-1:0]       cfg_gap,
  input  logic                        start,
  input  logic                        abort,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        sts_busy,
  output logic [BURST_WIDTH-1:0]      sts_burst,
  output logic                        sts_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [CNTR_WIDTH-1:0]   len_r, gap_r, beat_cnt, gap_cnt;
  logic [BURST_WIDTH-1:0]  bursts_r, burst_cnt;
  logic                    abort_pend, done_r;

  logic                    start_ok, xfer, last_beat, abort_eff, run_done;
  logic [BURST_WIDTH-1:0]  burst_inc;

  // A start is only honoured with a non-empty configuration and no abort.
  assign start_ok  = start & ~abort & (|cfg_length) & (|cfg_bursts);
  assign xfer      = (state_q == RUN) & m_axis_tready;
  // Full-width compare; beat_cnt never exceeds len_r-1 so it cannot wrap.
  assign last_beat = (beat_cnt == len_r - CNTR_WIDTH'(1));
  assign abort_eff = abort | abort_pend;
  assign burst_inc = burst_cnt + BURST_WIDTH'(1);
  // Normal completion takes priority over a coincident abort.
  assign run_done  = xfer & last_beat & (burst_inc == bursts_r);

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN: begin
        if (xfer) begin
          if (run_done)                  state_d = IDLE;
          else if (abort_eff)            state_d = IDLE;
          else if (last_beat)            state_d = (gap_r == '0) ? RUN : GAP;
        end
      end
      GAP: begin
        if (abort)                                   state_d = IDLE;
        else if (gap_cnt == gap_r - CNTR_WIDTH'(1))  state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registers only.
  always_comb begin
    m_axis_tvalid = (state_q == RUN);
    m_axis_tlast  = (state_q == RUN) & last_beat;
    m_axis_tdata  = AXIS_TDATA_WIDTH'(beat_cnt);
    sts_busy      = (state_q != IDLE);
    sts_burst     = burst_cnt;
    sts_done      = done_r;
  end

  // Shadow config, beat/gap counters, burst count, pending abort, done pulse.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      len_r      <= '0;
      gap_r      <= '0;
      bursts_r   <= '0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      burst_cnt  <= '0;
      abort_pend <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= run_done;
      case (state_q)
        IDLE: begin
          abort_pend <= 1'b0;
          if (start_ok) begin
            len_r     <= cfg_length;
            gap_r     <= cfg_gap;
            bursts_r  <= cfg_bursts;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            burst_cnt <= '0;
          end
        end
        RUN: begin
          gap_cnt    <= '0;
          // Abort waits for the held beat to be accepted.
          abort_pend <= abort_eff & ~xfer;
          if (xfer) begin
            // Clear on leaving the burst so IDLE/GAP always show tdata=0.
            if (last_beat || abort_eff) beat_cnt <= '0;
            else                        beat_cnt <= beat_cnt + CNTR_WIDTH'(1);
            if (last_beat)              burst_cnt <= burst_inc;
          end
        end
        GAP: begin
          abort_pend <= 1'b0;
          gap_cnt    <= gap_cnt + CNTR_WIDTH'(1);
        end
        default: abort_pend <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_burst_scheduler.sv
// Directed table-driven bench for axis_burst_scheduler, built with narrow
// counters so the full-width length boundary is reachable.
module tb_axis_burst_scheduler;

  localparam int DW = 8, CW = 4, BW = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [CW-1:0] cfg_length, cfg_gap;
  logic [BW-1:0] cfg_bursts;
  logic          start, abort, m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, sts_busy, sts_done;
  logic [BW-1:0] sts_burst;

  always #5 aclk = ~aclk;

  axis_burst_scheduler #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW), .BURST_WIDTH(BW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_length(cfg_length), .cfg_bursts(cfg_bursts), .cfg_gap(cfg_gap),
    .start(start), .abort(abort),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .sts_busy(sts_busy), .sts_burst(sts_burst), .sts_done(sts_done)
  );

  typedef struct {
    logic          rst_n, st, ab, rdy;
    logic [CW-1:0] len, gap;
    logic [BW-1:0] bur;
    logic          ev, el, eb, edn;
    logic [DW-1:0] ed;
    logic [BW-1:0] ebu;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0, n_err = 0;
  int   cl = 0, cb = 0, cg = 0;

  task automatic cfg(input int l, input int b, input int g);
    cl = l; cb = b; cg = g;
  endtask

  // One cycle: inputs (start, abort, tready), then outputs expected after the edge.
  task automatic add(input logic s, input logic a, input logic r,
                     input logic ev, input int ed, input logic el,
                     input logic eb, input int ebu, input logic edn);
    vec_t v;
    v.rst_n = 1'b1; v.st = s; v.ab = a; v.rdy = r;
    v.len = CW'(cl); v.bur = BW'(cb); v.gap = CW'(cg);
    v.ev = ev; v.ed = DW'(ed); v.el = el; v.eb = eb; v.ebu = BW'(ebu); v.edn = edn;
    vq.push_back(v);
  endtask

  // Reset cycle: every output returns to zero.
  task automatic addr(input logic r);
    add(1'b0, 1'b0, r, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    vq[vq.size()-1].rst_n = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int n;
    aresetn = 1'b0; start = 1'b0; abort = 1'b0; m_axis_tready = 1'b0;
    cfg_length = '0; cfg_bursts = '0; cfg_gap = '0;

    addr(0); addr(0);
    // length 4, bursts 2, gap 3
    cfg(4, 2, 3);
    add(1,0,1, 1,0,0,1,0,0);
    add(0,0,1, 1,1,0,1,0,0);
    add(0,0,1, 1,2,0,1,0,0);
    add(0,0,1, 1,3,1,1,0,0);
    add(0,0,1, 0,0,0,1,1,0);
    add(0,0,1, 0,0,0,1,1,0);
    add(0,0,1, 0,0,0,1,1,0);
    add(0,0,1, 1,0,0,1,1,0);
    add(0,0,1, 1,1,0,1,1,0);
    add(0,0,1, 1,2,0,1,1,0);
    add(0,0,1, 1,3,1,1,1,0);
    add(0,0,1, 0,0,0,0,2,1);
    add(0,0,1, 0,0,0,0,2,0);
    // length 3, bursts 2, gap 0, tready toggling
    cfg(3, 2, 0);
    add(1,0,0, 1,0,0,1,0,0);
    add(0,0,1, 1,1,0,1,0,0);
    add(0,0,0, 1,1,0,1,0,0);
    add(0,0,1, 1,2,1,1,0,0);
    add(0,0,0, 1,2,1,1,0,0);
    add(0,0,1, 1,0,0,1,1,0);
    add(0,0,0, 1,0,0,1,1,0);
    add(0,0,1, 1,1,0,1,1,0);
    add(0,0,0, 1,1,0,1,1,0);
    add(0,0,1, 1,2,1,1,1,0);
    add(0,0,0, 1,2,1,1,1,0);
    add(0,0,1, 0,0,0,0,2,1);
    // empty config and abort+start in IDLE are ignored; sts_burst kept
    cfg(0, 2, 0); add(1,0,1, 0,0,0,0,2,0);
    cfg(3, 0, 0); add(1,0,1, 0,0,0,0,2,0);
    cfg(3, 1, 0); add(1,1,1, 0,0,0,0,2,0);
    // length 5, abort at beat 2 with tready low for 4 cycles
    cfg(5, 1, 0);
    add(1,0,1, 1,0,0,1,0,0);
    add(0,0,1, 1,1,0,1,0,0);
    add(0,0,1, 1,2,0,1,0,0);
    add(0,1,0, 1,2,0,1,0,0);
    add(0,0,0, 1,2,0,1,0,0);
    add(0,0,0, 1,2,0,1,0,0);
    add(0,0,0, 1,2,0,1,0,0);
    add(0,0,1, 0,0,0,0,0,0);
    add(0,0,1, 0,0,0,0,0,0);
    // config change and start mid-run have no effect
    cfg(2, 1, 0); add(1,0,0, 1,0,0,1,0,0);
    cfg(7, 3, 0); add(1,0,1, 1,1,1,1,0,0);
    add(0,0,1, 0,0,0,0,1,1);
    // abort with final beat of final burst: normal completion
    cfg(1, 1, 0);
    add(1,0,0, 1,0,1,1,0,0);
    add(0,1,1, 0,0,0,0,1,1);
    add(0,0,0, 0,0,0,0,1,0);
    // abort held on tlast beat of a non-final burst: burst counted, no done
    cfg(2, 2, 0);
    add(1,0,0, 1,0,0,1,0,0);
    add(0,0,1, 1,1,1,1,0,0);
    add(0,1,0, 1,1,1,1,0,0);
    add(0,0,1, 0,0,0,0,1,0);
    // length 1, bursts 3, gap 1
    cfg(1, 3, 1);
    add(1,0,1, 1,0,1,1,0,0);
    add(0,0,1, 0,0,0,1,1,0);
    add(0,0,1, 1,0,1,1,1,0);
    add(0,0,1, 0,0,0,1,2,0);
    add(0,0,1, 1,0,1,1,2,0);
    add(0,0,1, 0,0,0,0,3,1);
    // abort during GAP
    cfg(1, 3, 2);
    add(1,0,1, 1,0,1,1,0,0);
    add(0,0,1, 0,0,0,1,1,0);
    add(0,1,1, 0,0,0,0,1,0);
    // reset mid-burst while stalled, then restart from zero
    cfg(4, 2, 1);
    add(1,0,1, 1,0,0,1,0,0);
    add(0,0,1, 1,1,0,1,0,0);
    addr(0);
    add(1,0,1, 1,0,0,1,0,0);
    add(0,0,1, 1,1,0,1,0,0);
    addr(1);
    // maximum length: no wrap before tlast
    cfg(15, 1, 0);
    add(1,0,1, 1,0,0,1,0,0);
    for (int i = 1; i <= 14; i++) add(0,0,1, 1,i,(i == 14),1,0,0);
    add(0,0,1, 0,0,0,0,1,1);

    for (int i = 0; i < vq.size(); i++) begin
      aresetn = vq[i].rst_n; start = vq[i].st; abort = vq[i].ab;
      m_axis_tready = vq[i].rdy;
      cfg_length = vq[i].len; cfg_bursts = vq[i].bur; cfg_gap = vq[i].gap;
      @(posedge aclk); #1;
      n_vec++;
      if (m_axis_tvalid !== vq[i].ev || m_axis_tdata !== vq[i].ed ||
          m_axis_tlast !== vq[i].el || sts_busy !== vq[i].eb ||
          sts_burst !== vq[i].ebu || sts_done !== vq[i].edn) begin
        n_err++;
        $display("FAIL vec%0d: got v=%b d=%0d l=%b busy=%b bur=%0d done=%b exp v=%b d=%0d l=%b busy=%b bur=%0d done=%b",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, sts_busy, sts_burst, sts_done,
                 vq[i].ev, vq[i].ed, vq[i].el, vq[i].eb, vq[i].ebu, vq[i].edn);
      end
    end

    // Hand sequence: length 3 single burst, wait (bounded) for sts_done.
    start = 1'b0; abort = 1'b0; m_axis_tready = 1'b0; aresetn = 1'b1;
    @(posedge aclk); #1;
    cfg_length = 4'd3; cfg_bursts = 4'd1; cfg_gap = 4'd0; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0; m_axis_tready = 1'b1;
    n = 0;
    while (!sts_done && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    check("done_latency", n, 3);
    check("done_burst", int'(sts_burst), 1);
    check("done_idle", int'(sts_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
